// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic light monitor: phase codes, FSM states and lamp payload.
package traffic_light_pkg;

    localparam int unsigned PHASE_W  = 2;
    localparam int unsigned CYCLES_W = 16;
    localparam int unsigned PROG_W   = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH_UNKNOWN = 2'd0,
        PH_RED     = 2'd1,
        PH_GREEN   = 2'd2,
        PH_YELLOW  = 2'd3
    } phase_e;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamps_t;

    // Legal successor in the RED -> GREEN -> YELLOW -> RED ring
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_phase_decode.sv
// One-hot lamp decode to a phase code; any other lamp pattern is flagged illegal.
module traffic_light_phase_decode
    import traffic_light_pkg::*;
(
    input  lamps_t lamps,
    output phase_e phase_c,
    output logic   illegal_c
);

    always_comb begin
        phase_c   = PH_UNKNOWN;
        illegal_c = 1'b0;
        case ({lamps.red, lamps.yellow, lamps.green})
            3'b100:  phase_c = PH_RED;
            3'b010:  phase_c = PH_YELLOW;
            3'b001:  phase_c = PH_GREEN;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp monitor: checks one-hot encoding, phase order and per-phase dwell limits.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RED_MIN    = 3,
    parameter int unsigned RED_MAX    = 8,
    parameter int unsigned GREEN_MIN  = 3,
    parameter int unsigned GREEN_MAX  = 8,
    parameter int unsigned YELLOW_MIN = 1,
    parameter int unsigned YELLOW_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                red,
    input  logic                yellow,
    input  logic                green,
    output logic [PHASE_W-1:0]  phase,
    output logic [CNT_W-1:0]    dwell,
    output logic [CYCLES_W-1:0] cycles,
    output logic                err_onehot,
    output logic                err_seq,
    output logic                err_dwell,
    output logic                err_pulse
);

    localparam int unsigned DWELL_TOP = (1 << CNT_W) - 1;

    if (!(RED_MIN >= 1 && RED_MIN <= RED_MAX && RED_MAX < DWELL_TOP &&
          GREEN_MIN >= 1 && GREEN_MIN <= GREEN_MAX && GREEN_MAX < DWELL_TOP &&
          YELLOW_MIN >= 1 && YELLOW_MIN <= YELLOW_MAX && YELLOW_MAX < DWELL_TOP))
    begin : g_param_check
        $error("traffic_light_monitor: dwell limits must satisfy 1<=MIN<=MAX<2^CNT_W-1");
    end

    function automatic logic [CNT_W-1:0] dwell_min(input phase_e p);
        case (p)
            PH_RED:    return CNT_W'(RED_MIN);
            PH_GREEN:  return CNT_W'(GREEN_MIN);
            PH_YELLOW: return CNT_W'(YELLOW_MIN);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dwell_max(input phase_e p);
        case (p)
            PH_RED:    return CNT_W'(RED_MAX);
            PH_GREEN:  return CNT_W'(GREEN_MAX);
            PH_YELLOW: return CNT_W'(YELLOW_MAX);
            default:   return '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    lamps_t              lamp_q, lamp_d;
    logic                lamp_vld_q, lamp_vld_d;
    phase_e              phase_q, phase_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [CYCLES_W-1:0] cycles_q, cycles_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic                exempt_q, exempt_d;
    logic                err_onehot_q, err_onehot_d;
    logic                err_seq_q, err_seq_d;
    logic                err_dwell_q, err_dwell_d;
    logic                err_pulse_q, err_pulse_d;

    phase_e dec_phase_c;
    logic   dec_illegal_c;

    traffic_light_phase_decode u_decode (
        .lamps     (lamp_q),
        .phase_c   (dec_phase_c),
        .illegal_c (dec_illegal_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            lamp_q       <= '0;
            lamp_vld_q   <= 1'b0;
            phase_q      <= PH_UNKNOWN;
            dwell_q      <= '0;
            cycles_q     <= '0;
            prog_q       <= '0;
            exempt_q     <= 1'b0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_dwell_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lamp_q       <= lamp_d;
            lamp_vld_q   <= lamp_vld_d;
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            cycles_q     <= cycles_d;
            prog_q       <= prog_d;
            exempt_q     <= exempt_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            err_dwell_q  <= err_dwell_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    // prog_q counts how many of RED, GREEN, YELLOW have been entered in order by a tracked transition
    always_comb begin
        state_d      = state_q;
        lamp_d       = lamps_t'({red, yellow, green});
        lamp_vld_d   = 1'b1;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        cycles_d     = cycles_q;
        prog_d       = prog_q;
        exempt_d     = exempt_q;
        err_onehot_d = err_onehot_q;
        err_seq_d    = err_seq_q;
        err_dwell_d  = err_dwell_q;
        err_pulse_d  = 1'b0;

        if (lamp_vld_q) begin
            if (dec_illegal_c) begin
                err_onehot_d = 1'b1;
                err_pulse_d  = 1'b1;
                phase_d      = PH_UNKNOWN;
                dwell_d      = '0;
                prog_d       = '0;
                exempt_d     = 1'b0;
                state_d      = ST_SYNC;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        phase_d  = dec_phase_c;
                        dwell_d  = CNT_W'(1);
                        prog_d   = '0;
                        exempt_d = 1'b1;
                        state_d  = ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (dec_phase_c == phase_q) begin
                            if (dwell_q != {CNT_W{1'b1}}) begin
                                dwell_d = dwell_q + CNT_W'(1);
                            end
                            if (dwell_q == dwell_max(phase_q)) begin
                                err_dwell_d = 1'b1;
                                err_pulse_d = 1'b1;
                            end
                        end else begin
                            if (!exempt_q && (dwell_q < dwell_min(phase_q))) begin
                                err_dwell_d = 1'b1;
                                err_pulse_d = 1'b1;
                            end
                            if (dec_phase_c != next_phase(phase_q)) begin
                                err_seq_d   = 1'b1;
                                err_pulse_d = 1'b1;
                            end
                            if (phase_q == PH_YELLOW && dec_phase_c == PH_RED && prog_q == PROG_W'(3)) begin
                                cycles_d = cycles_q + CYCLES_W'(1);
                            end
                            if (dec_phase_c == PH_RED) begin
                                prog_d = PROG_W'(1);
                            end else if (dec_phase_c == PH_GREEN && phase_q == PH_RED && prog_q == PROG_W'(1)) begin
                                prog_d = PROG_W'(2);
                            end else if (dec_phase_c == PH_YELLOW && phase_q == PH_GREEN && prog_q == PROG_W'(2)) begin
                                prog_d = PROG_W'(3);
                            end else begin
                                prog_d = '0;
                            end
                            phase_d  = dec_phase_c;
                            dwell_d  = CNT_W'(1);
                            exempt_d = 1'b0;
                        end
                    end
                    default: state_d = ST_SYNC;
                endcase
            end
        end
    end

    assign phase      = phase_q;
    assign dwell      = dwell_q;
    assign cycles     = cycles_q;
    assign err_onehot = err_onehot_q;
    assign err_seq    = err_seq_q;
    assign err_dwell  = err_dwell_q;
    assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with a run-history reference model and literal spot checks.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    logic        clk;
    logic        reset;
    logic        red, yellow, green;
    logic [1:0]  phase;
    logic [7:0]  dwell;
    logic [15:0] cycles;
    logic        err_onehot, err_seq, err_dwell, err_pulse;

    traffic_light_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .phase      (phase),
        .dwell      (dwell),
        .cycles     (cycles),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .err_dwell  (err_dwell),
        .err_pulse  (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    endtask

    // Reference model: phase index 0 unknown, 1 red, 2 green, 3 yellow
    int mn[4]  = '{0, 3, 3, 1};
    int mx[4]  = '{0, 8, 8, 3};
    int nxt[4] = '{0, 2, 3, 1};

    int         e_phase, e_dwell, e_cycles;
    bit         e_onehot, e_seq, e_dwell_err, e_pulse;
    bit         m_synced, m_first, m_vld;
    logic [2:0] m_pend;
    int         hist[$];

    task automatic model_step(input logic [2:0] s);
        int ph;
        int n;
        if ($countones(s) != 1) begin
            e_onehot = 1; e_pulse = 1;
            e_phase = 0; e_dwell = 0;
            m_synced = 0;
            hist.delete();
            return;
        end
        ph = (s == L_R) ? 1 : (s == L_G) ? 2 : 3;
        if (!m_synced) begin
            e_phase = ph; e_dwell = 1;
            m_synced = 1; m_first = 1;
            hist.delete();
        end else if (ph == e_phase) begin
            if (e_dwell < 255) e_dwell++;
            if (e_dwell == mx[ph] + 1) begin e_dwell_err = 1; e_pulse = 1; end
        end else begin
            if (!m_first && e_dwell < mn[e_phase]) begin e_dwell_err = 1; e_pulse = 1; end
            if (ph != nxt[e_phase]) begin e_seq = 1; e_pulse = 1; end
            hist.push_back(ph);
            n = hist.size();
            if (e_phase == 3 && ph == 1 && n >= 4 &&
                hist[n-4] == 1 && hist[n-3] == 2 && hist[n-2] == 3)
                e_cycles = (e_cycles + 1) % 65536;
            e_phase = ph; e_dwell = 1; m_first = 0;
        end
    endtask

    always @(posedge clk) begin
        e_pulse = 0;
        if (reset) begin
            e_phase = 0; e_dwell = 0; e_cycles = 0;
            e_onehot = 0; e_seq = 0; e_dwell_err = 0;
            m_synced = 0; m_first = 0; m_vld = 0;
            hist.delete();
        end else begin
            if (m_vld) model_step(m_pend);
            m_pend = {red, yellow, green};
            m_vld  = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase",      int'(phase),      e_phase);
            chk("dwell",      int'(dwell),      e_dwell);
            chk("cycles",     int'(cycles),     e_cycles);
            chk("err_onehot", int'(err_onehot), int'(e_onehot));
            chk("err_seq",    int'(err_seq),    int'(e_seq));
            chk("err_dwell",  int'(err_dwell),  int'(e_dwell_err));
            chk("err_pulse",  int'(err_pulse),  int'(e_pulse));
        end
    end

    task automatic drive(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            {red, yellow, green} = s;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {red, yellow, green} = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {red, yellow, green} = 3'b000;
        do_reset();
        chk_en = 1'b1;
        chk("lit_reset_phase",  int'(phase),  0);
        chk("lit_reset_dwell",  int'(dwell),  0);
        chk("lit_reset_cycles", int'(cycles), 0);
        chk("lit_reset_errs",   int'({err_onehot, err_seq, err_dwell, err_pulse}), 0);

        // First RED is adopted at sync, so the first loop does not count
        drive(L_R, 5); drive(L_G, 4); drive(L_Y, 2); drive(L_R, 1);
        chk("lit_loop1_phase",  int'(phase),  3);
        chk("lit_loop1_dwell",  int'(dwell),  2);
        chk("lit_loop1_cycles", int'(cycles), 0);
        drive(L_R, 3); drive(L_G, 4); drive(L_Y, 2); drive(L_R, 2);
        chk("lit_loop2_cycles", int'(cycles), 1);
        chk("lit_loop2_phase",  int'(phase),  1);
        chk("lit_loop2_errs",   int'({err_onehot, err_seq, err_dwell}), 0);

        // GREEN overstays its maximum
        drive(L_R, 2); drive(L_G, 9);
        chk("lit_gmax_before", int'(err_dwell), 0);
        drive(L_G, 1);
        chk("lit_gmax_flag",  int'(err_dwell), 1);
        chk("lit_gmax_pulse", int'(err_pulse), 1);
        drive(L_Y, 1);
        chk("lit_gmax_nopulse", int'(err_pulse), 0);
        chk("lit_gmax_dwell",   int'(dwell),     10);
        drive(L_Y, 2);

        // RED straight to YELLOW
        do_reset();
        drive(L_R, 5); drive(L_Y, 2);
        chk("lit_seq_flag",  int'(err_seq),   1);
        chk("lit_seq_phase", int'(phase),     3);
        chk("lit_seq_dwell", int'(dwell),     1);
        chk("lit_seq_dwerr", int'(err_dwell), 0);

        // Short GREEN after a tracked RED
        do_reset();
        drive(L_R, 4); drive(L_G, 4); drive(L_Y, 2); drive(L_R, 4); drive(L_G, 2); drive(L_Y, 2);
        chk("lit_gmin_flag", int'(err_dwell), 1);
        chk("lit_gmin_seq",  int'(err_seq),   0);

        // Short GREEN exiting to RED: two violations, one pulse
        do_reset();
        drive(L_R, 4); drive(L_G, 4); drive(L_Y, 2); drive(L_R, 4); drive(L_G, 2); drive(L_R, 2);
        chk("lit_multi_dwell", int'(err_dwell), 1);
        chk("lit_multi_seq",   int'(err_seq),   1);
        chk("lit_multi_pulse", int'(err_pulse), 1);
        drive(L_R, 1);
        chk("lit_multi_once",  int'(err_pulse), 0);

        // Two lamps lit, then resync on RED with MIN exemption
        do_reset();
        drive(L_R, 4); drive(L_G, 4); drive(3'b101, 1); drive(L_R, 1);
        chk("lit_oh_flag",  int'(err_onehot), 1);
        chk("lit_oh_phase", int'(phase),      0);
        chk("lit_oh_dwell", int'(dwell),      0);
        drive(L_R, 1);
        chk("lit_resync_phase", int'(phase), 1);
        chk("lit_resync_dwell", int'(dwell), 1);
        drive(L_G, 2);
        chk("lit_exempt_phase", int'(phase),     2);
        chk("lit_exempt_dwell", int'(err_dwell), 0);

        // Reset mid-GREEN with a sticky flag set
        reset = 1'b1;
        @(negedge clk);
        chk("lit_rst_phase", int'(phase),  0);
        chk("lit_rst_dwell", int'(dwell),  0);
        chk("lit_rst_errs",  int'({err_onehot, err_seq, err_dwell, err_pulse}), 0);
        @(negedge clk);
        reset = 1'b0;

        // YELLOW over maximum on the sync-adopted phase, then an all-dark sample
        drive(L_Y, 5);
        chk("lit_ymax_flag",  int'(err_dwell), 1);
        chk("lit_ymax_dwell", int'(dwell),     4);
        chk("lit_ymax_pulse", int'(err_pulse), 1);
        drive(3'b000, 1); drive(L_R, 1);
        chk("lit_dark_flag",  int'(err_onehot), 1);
        chk("lit_dark_phase", int'(phase),      0);
        drive(L_R, 3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
